// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: streams a program image into the instruction memory,
// then fetches from it into an instruction register with stall, branch and halt handling.
module instruction_fetch_controller #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        LoadValid,
    input  logic [15:0] LoadData,
    input  logic        LoadLast,
    output logic        LoadReady,
    input  logic        Start,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [15:0] BranchTarget,
    output logic [15:0] MemAddress,
    output logic [15:0] MemWriteData,
    output logic        MemWrite,
    input  logic [15:0] MemInstruction,
    output logic [15:0] PC,
    output logic [15:0] Instruction,
    output logic        InstrValid,
    output logic        Halted,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] load_ptr_q;
    logic [15:0] instr_q;
    logic        instr_valid_q;
    logic        halted_q;

    // Memory port is shared: the load pointer owns it while loading, the PC otherwise.
    assign LoadReady    = (state_q == S_LOAD);
    assign MemWrite     = (state_q == S_LOAD) && LoadValid;
    assign MemAddress   = (state_q == S_LOAD) ? load_ptr_q : pc_q;
    assign MemWriteData = LoadData;

    assign PC          = pc_q;
    assign Instruction = instr_q;
    assign InstrValid  = instr_valid_q;
    assign Halted      = halted_q;
    assign State       = state_q;

    // NOTE: all state lives in one clocked block and uses non-blocking assignments,
    // so every register sees the values from before this edge regardless of order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            // NOTE: the program memory is external and deliberately not cleared;
            // a partial image survives reset and is simply overwritten by the next load.
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            load_ptr_q    <= RESET_PC;
            instr_q       <= 16'h0000;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (LoadValid) begin
                        state_q <= S_LOAD;
                    end else if (Start) begin
                        state_q <= S_RUN;
                        pc_q    <= RESET_PC;
                    end
                end
                S_LOAD: begin
                    if (LoadValid) begin
                        if (LoadLast) begin
                            state_q    <= S_IDLE;
                            load_ptr_q <= RESET_PC;
                        end else begin
                            load_ptr_q <= load_ptr_q + 16'd2;
                        end
                    end
                end
                S_RUN: begin
                    // Redirect beats stall; the halt check only applies to a word we would consume.
                    if (BranchTaken) begin
                        pc_q          <= BranchTarget & 16'hFFFE;
                        instr_valid_q <= 1'b0;
                    end else if (!Stall) begin
                        if (MemInstruction == HALT_WORD) begin
                            state_q       <= S_HALT;
                            halted_q      <= 1'b1;
                            instr_valid_q <= 1'b0;
                        end else begin
                            instr_q       <= MemInstruction;
                            instr_valid_q <= 1'b1;
                            pc_q          <= pc_q + 16'd2;
                        end
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Self-checking bench: directed scenarios plus randomized load/run episodes compared
// cycle by cycle against an abstract phase/PC model with its own copy of the program image.
module tb_instruction_fetch_controller;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] HALT_WORD = 16'hFFFF;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        LoadValid;
    logic [15:0] LoadData;
    logic        LoadLast;
    logic        LoadReady;
    logic        Start;
    logic        Stall;
    logic        BranchTaken;
    logic [15:0] BranchTarget;
    logic [15:0] MemAddress;
    logic [15:0] MemWriteData;
    logic        MemWrite;
    logic [15:0] MemInstruction;
    logic [15:0] PC;
    logic [15:0] Instruction;
    logic        InstrValid;
    logic        Halted;
    logic [1:0]  State;

    instruction_fetch_controller #(
        .RESET_PC (RESET_PC),
        .HALT_WORD(HALT_WORD)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .LoadValid     (LoadValid),
        .LoadData      (LoadData),
        .LoadLast      (LoadLast),
        .LoadReady     (LoadReady),
        .Start         (Start),
        .Stall         (Stall),
        .BranchTaken   (BranchTaken),
        .BranchTarget  (BranchTarget),
        .MemAddress    (MemAddress),
        .MemWriteData  (MemWriteData),
        .MemWrite      (MemWrite),
        .MemInstruction(MemInstruction),
        .PC            (PC),
        .Instruction   (Instruction),
        .InstrValid    (InstrValid),
        .Halted        (Halted),
        .State         (State)
    );

    always #5 Clock = ~Clock;

    // Instruction memory as driven by the DUT's write port.
    logic [15:0] dut_mem [0:32767];
    assign MemInstruction = dut_mem[MemAddress[15:1]];
    always @(posedge Clock) begin
        if (MemWrite) dut_mem[MemAddress[15:1]] <= MemWriteData;
    end

    // Reference model: phase 0 idle, 1 loading, 2 running, 3 halted.
    logic [15:0] ref_mem [0:32767];
    int          m_phase;
    logic [15:0] m_pc;
    logic [15:0] m_lptr;
    logic [15:0] m_instr;
    logic        m_iv;
    logic        m_halted;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_pc     = RESET_PC;
        m_lptr   = RESET_PC;
        m_instr  = 16'h0000;
        m_iv     = 1'b0;
        m_halted = 1'b0;
    endtask

    // One clock cycle: drive inputs, check everything against the model, advance the model.
    task automatic step(input logic rst, input logic lv, input logic [15:0] ld, input logic ll,
                        input logic st, input logic stl, input logic bt, input logic [15:0] tgt);
        logic [15:0] word;
        @(negedge Clock);
        Reset = rst; LoadValid = lv; LoadData = ld; LoadLast = ll;
        Start = st; Stall = stl; BranchTaken = bt; BranchTarget = tgt;
        #1;
        check("state",       32'(State),        32'(m_phase));
        check("pc",          32'(PC),           32'(m_pc));
        check("instruction", 32'(Instruction),  32'(m_instr));
        check("instr_valid", 32'(InstrValid),   32'(m_iv));
        check("halted",      32'(Halted),       32'(m_halted));
        check("load_ready",  32'(LoadReady),    32'(m_phase == 1));
        check("mem_write",   32'(MemWrite),     32'(m_phase == 1 && lv));
        check("mem_addr",    32'(MemAddress),   32'(m_phase == 1 ? m_lptr : m_pc));
        check("mem_wdata",   32'(MemWriteData), 32'(ld));
        if (rst) begin
            model_reset();
        end else begin
            case (m_phase)
                0: begin
                    if (lv) m_phase = 1;
                    else if (st) begin m_phase = 2; m_pc = RESET_PC; end
                end
                1: begin
                    if (lv) begin
                        ref_mem[m_lptr / 2] = ld;
                        m_lptr = m_lptr + 16'd2;
                        if (ll) begin m_phase = 0; m_lptr = RESET_PC; end
                    end
                end
                2: begin
                    word = ref_mem[m_pc / 2];
                    if (bt) begin
                        m_pc = {tgt[15:1], 1'b0};
                        m_iv = 1'b0;
                    end else if (!stl) begin
                        if (word == HALT_WORD) begin
                            m_phase = 3; m_halted = 1'b1; m_iv = 1'b0;
                        end else begin
                            m_instr = word; m_iv = 1'b1; m_pc = m_pc + 16'd2;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic do_reset();
        step(1, 0, 16'h0, 0, 0, 0, 0, 16'h0);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        step(0, 1, d, last, 0, 0, 0, 16'h0);
    endtask

    // Randomized episode: load a short image, run with random stalls/branches, maybe reset mid-way.
    task automatic random_episode();
        int n;
        logic [15:0] d;
        logic [15:0] tgt;
        do_reset();
        n = $urandom_range(1, 12);
        for (int i = 0; i < n; i++) begin
            d = ($urandom_range(0, 9) == 0) ? HALT_WORD : 16'($urandom);
            if ($urandom_range(0, 3) == 0)
                step(0, 0, 16'($urandom), 1'($urandom), 1'($urandom), 0, 0, 16'h0);
            if ($urandom_range(0, 40) == 0) begin
                do_reset();
                return;
            end
            step(0, 1, d, (i == n - 1), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
        end
        idle($urandom_range(0, 2));
        step(0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
        for (int c = 0; c < 30; c++) begin
            tgt = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 2 * n + 3)) : 16'($urandom);
            step(0, ($urandom_range(0, 5) == 0), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), tgt);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            dut_mem[i] = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        Reset = 1'b1; LoadValid = 1'b0; LoadData = 16'h0; LoadLast = 1'b0;
        Start = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0;
        model_reset();

        // Load three words, then run and exercise stall and branch-over-stall.
        do_reset();
        load_word(16'h1111, 0);
        load_word(16'h2222, 0);
        load_word(16'h3333, 1);
        idle(1);
        step(0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
        idle(3);
        step(0, 0, 16'h0, 0, 0, 1, 0, 16'h0);
        step(0, 0, 16'h0, 0, 0, 1, 0, 16'h0);
        step(0, 0, 16'h0, 0, 0, 1, 1, 16'h0013);
        idle(3);

        // Halt detection and the terminal halted state.
        do_reset();
        load_word(16'h1111, 0);
        load_word(HALT_WORD, 0);
        load_word(16'h2222, 1);
        step(0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
        idle(3);
        step(0, 1, 16'hABCD, 0, 1, 1, 1, 16'h0040);
        step(0, 1, 16'hABCD, 1, 1, 0, 0, 16'h0);
        idle(1);

        // Reset in the middle of a load, then a fresh load restarting at RESET_PC.
        do_reset();
        load_word(16'hAAAA, 0);
        load_word(16'hBBBB, 0);
        load_word(16'hCCCC, 0);
        do_reset();
        idle(1);
        load_word(16'hDDDD, 0);
        load_word(16'hEEEE, 1);
        idle(1);

        // Loader wraps past FFFE, then a branch to FFFE wraps the PC.
        do_reset();
        for (int i = 0; i < 32770; i++) load_word({1'b0, 15'(i)}, (i == 32769));
        step(0, 0, 16'h0, 0, 1, 0, 0, 16'h0);
        idle(2);
        step(0, 0, 16'h0, 0, 0, 0, 1, 16'hFFFF);
        idle(3);

        for (int e = 0; e < 60; e++) random_episode();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
